// File: rtl/uart_tx_pkg.sv
// Shared UART constants and helpers used by the transmitter and the receiver.
package uart_tx_pkg;

    // Bit periods in clk cycles: 115200 baud and 4M baud from 125 MHz.
    localparam int unsigned SlowBitDefault = 1085;
    localparam int unsigned FastBitDefault = 31;

    // Bit-period counter width; 11 bits covers SlowBitDefault - 1.
    localparam int unsigned CntW = 11;

    // Reload value for the bit counter: one less than the selected period.
    function automatic logic [CntW-1:0] bit_reload(input logic fast,
                                                   input int unsigned slow_bit,
                                                   input int unsigned fast_bit);
        int unsigned period;
        period = fast ? fast_bit : slow_bit;
        return CntW'(period - 1);
    endfunction

endpackage

// File: rtl/uart_baud.sv
// Loadable bit-period down-counter with period select and terminal-count flag.
module uart_baud
    import uart_tx_pkg::*;
#(
    parameter int unsigned SLOW_BIT = SlowBitDefault,
    parameter int unsigned FAST_BIT = FastBitDefault
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic fast_i,
    output logic tc_o
);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: reload on a bit boundary, otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = bit_reload(fast_i, SLOW_BIT, FAST_BIT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // Counter register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// 8n1 UART transmitter with valid/ready byte input and selectable bit period.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned SLOW_BIT = SlowBitDefault,
    parameter int unsigned FAST_BIT = FastBitDefault
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    input  logic       high_speed,
    output logic       tx
);

    typedef enum logic [3:0] {
        StIdle,
        StStart,
        StD0,
        StD1,
        StD2,
        StD3,
        StD4,
        StD5,
        StD6,
        StD7,
        StStop
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] data_q, data_d;
    logic       fast_q, fast_d;
    logic       tx_q, tx_d;
    logic       ready_q, ready_d;
    logic       accept;
    logic       load;
    logic       baud_fast;
    logic       tc;
    logic [2:0] bit_idx;

    // ready_q is only ever high in idle, so this implies the idle state.
    assign accept = valid && ready_q;

    // On acceptance the counter must use the incoming period, not the stale latch.
    assign baud_fast = (state_q == StIdle) ? high_speed : fast_q;

    uart_baud #(
        .SLOW_BIT (SLOW_BIT),
        .FAST_BIT (FAST_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .fast_i (baud_fast),
        .tc_o   (tc)
    );

    // Next state, byte/period latching and bit-boundary reload.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        fast_d  = fast_q;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StStart;
                    data_d  = data;
                    fast_d  = high_speed;
                    load    = 1'b1;
                end
            end
            StStop: begin
                if (tc) begin
                    state_d = StIdle;
                end
            end
            default: begin
                if (tc) begin
                    state_d = state_e'(state_q + 4'd1);
                    load    = 1'b1;
                end
            end
        endcase
    end

    // Line level and ready are decoded from the next state so both are registered.
    assign bit_idx = 3'(state_d - StD0);

    always_comb begin
        tx_d    = 1'b1;
        ready_d = (state_d == StIdle);
        unique case (state_d)
            StIdle, StStop: tx_d = 1'b1;
            StStart:        tx_d = 1'b0;
            default:        tx_d = data_d[bit_idx];
        endcase
    end

    // Control state; reset aborts any frame and holds the line high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            tx_q    <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
        end
    end

    // Frame payload latches; contents are irrelevant until the next acceptance.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        fast_q <= fast_d;
    end

    assign tx    = tx_q;
    assign ready = ready_q;

endmodule
